prg_upload: RTL and testbench
=============================

# prg_upload

Reads the BASIC program area of VIC-20 memory and streams it out as a PRG image: two-byte little-endian load address, then the program bytes. It is the reverse of the PRG download/register-inject path. It reads the start/end pointers from zero page, fetches each byte through a request/acknowledge memory port (arbitrated onto SDRAM by the top level) and hands bytes one at a time to the SPI upload side over a valid/ready handshake.

## Interface
Parameters:
- PTR_BASE, 16'h002B, zero-page address of the start pointer (lo, hi); the end pointer follows at PTR_BASE+2/+3.

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- abort  in  1  level; forces IDLE on the next edge.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.
- byte_count  out  17  bytes accepted so far, including the header.
- mem_req  out  1  memory read request; held until mem_ack.
- mem_addr  out  16  read address; stable while mem_req is high.
- mem_ack  in  1  one-cycle pulse; mem_data is valid in the same cycle.
- mem_data  in  8  read data.
- up_valid  out  1  up_data is valid.
- up_data  out  8  output byte.
- up_ready  in  1  consumer accepts the byte when up_valid & up_ready.

## Operation
- States: IDLE, PTR0, PTR1, PTR2, PTR3, HDR_LO, HDR_HI, FETCH, SEND, FINISH.
- IDLE:
  - When start=1: clear byte_count and go to PTR0.
- PTR0..PTR3:
  - Read PTR_BASE+0..+3 into start_lo, start_hi, end_lo, end_hi, one read per state.
  - Advance on mem_ack.
- HDR_LO, HDR_HI:
  - Present start_lo, then start_hi, on up_data.
  - Advance on transfer.
  - Load cur_addr = start.
- Leaving HDR_HI:
  - If end > start (unsigned 16-bit compare), go to FETCH.
  - Otherwise go to FINISH. The end pointer is exclusive, so end <= start means an empty body.
- FETCH:
  - mem_req=1 with mem_addr=cur_addr.
  - On mem_ack, latch mem_data into the output register and go to SEND.
- SEND:
  - Hold up_valid=1 until transfer.
  - On transfer, cur_addr += 1 (16-bit, wraps).
  - If the new cur_addr == end, go to FINISH; otherwise go to FETCH.
- FINISH: pulse done for one cycle, then go to IDLE.
- byte_count increments on every transfer, header bytes included.
- abort:
  - Has priority over all transitions.
  - Next state is IDLE; mem_req and up_valid drop.
  - done is not pulsed; byte_count holds its value.
- start while busy is ignored.
- start and abort in the same IDLE cycle: abort wins and the FSM stays in IDLE.
- A mem_ack arriving outside PTRx/FETCH is ignored.

## Timing
- Reset values:
  - state IDLE.
  - busy, done, mem_req, up_valid: 0.
  - mem_addr, up_data, byte_count, all internal pointers: 0.
- busy goes high the cycle after start is sampled.
- mem_req is registered:
  - It asserts the cycle after entry to PTRx/FETCH.
  - It deasserts the cycle after mem_ack.
  - It never asserts while up_valid is high.
- up_valid:
  - Asserts the cycle after mem_ack (data path) or on entry to HDR_LO/HDR_HI.
  - up_data is stable while up_valid is high and up_ready is low.
- Back-to-back, with zero-latency ack and up_ready tied high: one body byte every 3 cycles (FETCH req, ack/latch, SEND transfer).
- done asserts the cycle after the final transfer. busy falls the cycle after done.
- Reset mid-operation clears everything immediately (asynchronously). No partial byte is emitted after reset.

## Structure
- Shared package vic20_upload_pkg:
  - upload_state_t enum.
  - PTR_LO/PTR_HI offset constants.
  - PRG header length constant (2).
- Single module prg_upload with no sub-module. It is one FSM plus an address counter and an output register (~150–200 lines).
- The top level muxes mem_req/mem_addr onto the existing SDRAM port and steers it with oe when no download is active.

## Test plan
- Pointers $1001 and $1004; memory $1001..$1003 = AA BB CC → stream 01 10 AA BB CC; done pulses once; byte_count=5.
- start=$1200, end=$1200 → stream 00 12 only, no FETCH; byte_count=2; done pulses.
- start=$2000, end=$1000 → header 00 20 only; no body reads issued.
- Hold up_ready low for 10 cycles on the 2nd body byte → up_data stable, up_valid high, mem_req low throughout; stream intact afterwards.
- Assert abort during FETCH with mem_ack withheld → IDLE next cycle; mem_req=0, busy=0; no done; a later ack is ignored; a new start completes normally.
- Assert reset asynchronously mid-SEND → all outputs 0 immediately. Also: a start pulse while busy leaves the transfer unaffected; mem_ack latency of 0 vs 7 cycles yields an identical stream.

Source files
------------

// File: rtl/vic20_upload_pkg.sv
// rtl/vic20_upload_pkg.sv - shared types and constants for the PRG upload path
package vic20_upload_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PTR0,
        PTR1,
        PTR2,
        PTR3,
        HDR_LO,
        HDR_HI,
        FETCH,
        SEND,
        FINISH
    } upload_state_t;

    // Offsets within a zero-page pointer pair, and from the start pair to the end pair
    localparam logic [15:0] PTR_LO  = 16'd0;
    localparam logic [15:0] PTR_HI  = 16'd1;
    localparam logic [15:0] PTR_END = 16'd2;

    localparam logic [16:0] HDR_LEN = 17'd2;

endpackage

// File: rtl/prg_upload.sv
// rtl/prg_upload.sv - streams the BASIC program area out as a PRG image
module prg_upload
    import vic20_upload_pkg::*;
#(
    parameter logic [15:0] PTR_BASE = 16'h002B
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [16:0] byte_count,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        up_valid,
    output logic [7:0]  up_data,
    input  logic        up_ready
);

    upload_state_t state;
    logic [15:0]   start_addr;
    logic [15:0]   end_addr;
    logic [15:0]   cur_addr;
    logic [15:0]   next_addr;
    logic          transfer;
    logic          ack_ok;

    assign transfer  = up_valid & up_ready;
    // An ack only counts against a request we actually raised
    assign ack_ok    = mem_req & mem_ack;
    assign next_addr = cur_addr + 16'd1;

    function automatic logic [15:0] ptr_addr(input upload_state_t s);
        case (s)
            PTR0:    ptr_addr = PTR_BASE + PTR_LO;
            PTR1:    ptr_addr = PTR_BASE + PTR_HI;
            PTR2:    ptr_addr = PTR_BASE + PTR_END + PTR_LO;
            default: ptr_addr = PTR_BASE + PTR_END + PTR_HI;
        endcase
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            up_valid   <= 1'b0;
            up_data    <= '0;
            start_addr <= '0;
            end_addr   <= '0;
            cur_addr   <= '0;
        end else if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_req  <= 1'b0;
            up_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        byte_count <= '0;
                        busy       <= 1'b1;
                        state      <= PTR0;
                    end
                end
                PTR0, PTR1, PTR2, PTR3: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= ptr_addr(state);
                    end else if (ack_ok) begin
                        mem_req <= 1'b0;
                        case (state)
                            PTR0: begin
                                start_addr[7:0] <= mem_data;
                                state           <= PTR1;
                            end
                            PTR1: begin
                                start_addr[15:8] <= mem_data;
                                state            <= PTR2;
                            end
                            PTR2: begin
                                end_addr[7:0] <= mem_data;
                                state         <= PTR3;
                            end
                            default: begin
                                end_addr[15:8] <= mem_data;
                                up_data        <= start_addr[7:0];
                                up_valid       <= 1'b1;
                                state          <= HDR_LO;
                            end
                        endcase
                    end
                end
                HDR_LO: begin
                    if (transfer) begin
                        byte_count <= byte_count + 17'd1;
                        up_data    <= start_addr[15:8];
                        state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (transfer) begin
                        byte_count <= HDR_LEN;
                        up_valid   <= 1'b0;
                        cur_addr   <= start_addr;
                        // End pointer is exclusive: end <= start is an empty body
                        if (end_addr > start_addr) begin
                            state <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FETCH: begin
                    if (!mem_req) begin
                        mem_req  <= 1'b1;
                        mem_addr <= cur_addr;
                    end else if (ack_ok) begin
                        mem_req  <= 1'b0;
                        up_data  <= mem_data;
                        up_valid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        byte_count <= byte_count + 17'd1;
                        up_valid   <= 1'b0;
                        cur_addr   <= next_addr;
                        if (next_addr == end_addr) begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prg_upload.sv
// tb/tb_prg_upload.sv - self-checking bench for prg_upload
module tb_prg_upload;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic [16:0] byte_count;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_data = 8'h00;
    logic        up_valid;
    logic [7:0]  up_data;
    logic        up_ready = 1'b1;

    prg_upload #(.PTR_BASE(16'h002B)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .byte_count (byte_count),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_data   (mem_data),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] s;
        logic [15:0] e;
        int          lat;
        int          stall_at;
        bit          poke;
        int          exp_count;
    } vec_t;

    logic [7:0] mem [0:65535];
    logic [7:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    int n_reads = 0;
    int done_cnt = 0;
    int xfer_cnt = 0;
    int stall_seen = 0;
    int ack_lat = 0;
    int wait_cnt = 0;
    int stall_at = -1;
    int stall_left = 0;
    bit ack_hold = 0;
    bit stray_ack = 0;
    bit force_low = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory responder with programmable ack latency
    always @(posedge clk_sys) begin
        #1;
        mem_ack = 1'b0;
        if (stray_ack) begin
            mem_ack   = 1'b1;
            mem_data  = 8'h5A;
            stray_ack = 0;
        end else if (mem_req && !ack_hold) begin
            if (wait_cnt >= ack_lat) begin
                mem_ack  = 1'b1;
                mem_data = mem[mem_addr];
                wait_cnt = 0;
                n_reads++;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Consumer: stalls for ten valid cycles on the selected byte
    always @(posedge clk_sys) begin
        #1;
        if (force_low) begin
            up_ready = 1'b0;
        end else if (up_valid && stall_left > 0 && xfer_cnt == stall_at) begin
            up_ready = 1'b0;
            stall_left--;
        end else begin
            up_ready = 1'b1;
        end
    end

    // Scoreboard and protocol monitor
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (up_valid) check("req_while_valid", {31'd0, mem_req}, 32'd0);
            if (prev_stall && up_valid) check("stall_data_stable", {24'd0, up_data}, {24'd0, prev_data});
            if (up_valid && !up_ready) stall_seen++;
            if (up_valid && up_ready) begin
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'd0, up_data}, 32'hFFFF_FFFF);
                end else begin
                    check("stream_byte", {24'd0, up_data}, {24'd0, exp_q.pop_front()});
                end
            end
            if (done) done_cnt++;
        end
        prev_stall = up_valid && !up_ready;
        prev_data  = up_data;
    end

    task automatic set_ptrs(input logic [15:0] s, input logic [15:0] e);
        mem[16'h002B] = s[7:0];
        mem[16'h002C] = s[15:8];
        mem[16'h002D] = e[7:0];
        mem[16'h002E] = e[15:8];
    endtask

    task automatic pulse_start();
        @(posedge clk_sys); #1;
        start = 1'b1;
        @(posedge clk_sys); #1;
        start = 1'b0;
        @(negedge clk_sys);
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int body;
        int r0;
        int d0;
        bit got;
        logic [15:0] a;
        set_ptrs(v.s, v.e);
        ack_lat    = v.lat;
        stall_at   = v.stall_at;
        stall_left = (v.stall_at >= 0) ? 10 : 0;
        stall_seen = 0;
        xfer_cnt   = 0;
        exp_q.push_back(v.s[7:0]);
        exp_q.push_back(v.s[15:8]);
        body = (v.e > v.s) ? int'(v.e) - int'(v.s) : 0;
        for (int i = 0; i < body; i++) begin
            a = v.s + 16'(i);
            exp_q.push_back(mem[a]);
        end
        r0 = n_reads;
        d0 = done_cnt;
        pulse_start();
        got = 0;
        for (int c = 0; c < 3000 && !got; c++) begin
            @(posedge clk_sys); #1;
            start = (v.poke && c == 15) ? 1'b1 : 1'b0;
            @(negedge clk_sys);
            if (done) got = 1;
        end
        start = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        @(negedge clk_sys);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk_sys);
        check("done_pulses", done_cnt - d0, 32'd1);
        check("byte_count", {15'd0, byte_count}, v.exp_count);
        check("stream_drained", exp_q.size(), 32'd0);
        check("mem_reads", n_reads - r0, 4 + body);
        if (v.stall_at >= 0) check("stall_cycles", stall_seen, 32'd10);
        exp_q.delete();
    endtask

    vec_t vecs[7];

    initial begin
        int d0;
        int x0;
        bit got;
        vecs[0] = '{16'h1001, 16'h1004, 0, -1, 0, 5};
        vecs[1] = '{16'h1200, 16'h1200, 0, -1, 0, 2};
        vecs[2] = '{16'h2000, 16'h1000, 0, -1, 0, 2};
        vecs[3] = '{16'h3000, 16'h3006, 7, -1, 1, 8};
        vecs[4] = '{16'h3000, 16'h3006, 0, -1, 0, 8};
        vecs[5] = '{16'h4000, 16'h4004, 2, 3, 0, 6};
        vecs[6] = '{16'hFFFD, 16'hFFFF, 1, -1, 0, 4};

        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h3C;
        end
        mem[16'h1001] = 8'hAA;
        mem[16'h1002] = 8'hBB;
        mem[16'h1003] = 8'hCC;

        @(negedge clk_sys);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outputs", {done, mem_req, up_valid, mem_addr, up_data}, 32'd0);
        check("rst_count", {15'd0, byte_count}, 32'd0);
        @(posedge clk_sys); #1;
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Abort during FETCH with the ack withheld
        set_ptrs(16'h5000, 16'h5003);
        ack_lat  = 0;
        ack_hold = 0;
        xfer_cnt = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h50);
        d0 = done_cnt;
        pulse_start();
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk_sys); #1;
            if (xfer_cnt == 2) ack_hold = 1;
            @(negedge clk_sys);
            if (mem_req && ack_hold) got = 1;
        end
        check("abort_reached_fetch", {31'd0, got}, 32'd1);
        @(posedge clk_sys); #1;
        abort = 1'b1;
        @(posedge clk_sys); #1;
        abort = 1'b0;
        @(negedge clk_sys);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_req", {31'd0, mem_req}, 32'd0);
        check("abort_count_held", {15'd0, byte_count}, 32'd2);
        ack_hold  = 0;
        stray_ack = 1;
        repeat (6) @(negedge clk_sys);
        check("stray_ack_busy", {31'd0, busy}, 32'd0);
        check("stray_ack_valid", {31'd0, up_valid}, 32'd0);
        check("abort_no_done", done_cnt - d0, 32'd0);
        check("abort_stream", exp_q.size(), 32'd0);
        exp_q.delete();
        run_vec(vecs[0]);

        // Asynchronous reset while a body byte waits in SEND
        set_ptrs(16'h6000, 16'h6004);
        ack_lat  = 0;
        xfer_cnt = 0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h60);
        exp_q.push_back(mem[16'h6000]);
        pulse_start();
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge clk_sys); #1;
            if (xfer_cnt >= 2) force_low = 1;
            @(negedge clk_sys);
            if (up_valid && force_low) got = 1;
        end
        check("reset_reached_send", {31'd0, got}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_flags", {busy, done, mem_req, up_valid}, 32'd0);
        check("async_rst_data", {mem_addr, up_data}, 32'd0);
        check("async_rst_count", {15'd0, byte_count}, 32'd0);
        exp_q.delete();
        force_low = 0;
        x0 = xfer_cnt;
        @(posedge clk_sys); #1;
        reset = 1'b0;
        repeat (20) @(negedge clk_sys);
        check("no_byte_after_reset", xfer_cnt - x0, 32'd0);
        run_vec(vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
